// File: rtl/mem_arb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package    : mem_arb_pkg                                         |
// | Description: Shared types and constants for mem_port_arbiter.    |
// | Revision   : 1.0 - initial release                               |
// +------------------------------------------------------------------+
package mem_arb_pkg;

  // Access sequencer states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } arb_state_e;

  // Port identifiers as carried on gnt_id
  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_LDR  = 1'b1;

  // Width of the latency down-counter; clamped so an illegal latency
  // still elaborates far enough to reach the latency check.
  function automatic int unsigned cnt_width(input int unsigned lat);
    return (lat < 1) ? 1 : $clog2(lat + 1);
  endfunction

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Interface  : mem_port_arbiter_if                                 |
// | Description: Requester ports and memory-macro port of the        |
// |              unified memory arbiter.                             |
// | Revision   : 1.0 - initial release                               |
// +------------------------------------------------------------------+
interface mem_port_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  // Core requester
  logic          c_req;
  logic          c_we;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic          c_ack;
  // Loader / DMA requester
  logic          l_req;
  logic          l_we;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_wdata;
  logic          l_ack;
  // Shared response
  logic [DW-1:0] rdata;
  // Memory macro side
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  // Status
  logic          busy;
  logic          gnt_id;

  // Arbiter side
  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    input  l_req, l_we, l_addr, l_wdata,
    input  mem_rdata,
    output c_ack, l_ack, rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output busy, gnt_id
  );

  // Environment side: requesters and memory macro
  modport master (
    output c_req, c_we, c_addr, c_wdata,
    output l_req, l_we, l_addr, l_wdata,
    output mem_rdata,
    input  c_ack, l_ack, rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  busy, gnt_id
  );
endinterface : mem_port_arbiter_if
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module     : rr_arb2                                             |
// | Description: Two-way arbiter, round-robin or fixed core priority.|
// | Revision   : 1.0 - initial release                               |
// +------------------------------------------------------------------+
module rr_arb2 #(
  parameter bit RR = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic       winner
);
  import mem_arb_pkg::*;

  logic last_gnt_q;
  logic last_gnt_d;

  // Winner select: a tie goes away from the last grant, or always to the core
  always_comb begin
    winner = PORT_CORE;
    if (req == 2'b11) begin
      winner = RR ? ~last_gnt_q : PORT_CORE;
    end else if (req[1]) begin
      winner = PORT_LDR;
    end
  end

  // Pointer moves only when a grant is actually taken
  always_comb begin
    last_gnt_d = last_gnt_q;
    if (update) begin
      last_gnt_d = winner;
    end
  end

  // Pointer register; reset to loader so the core wins the first tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt_q <= PORT_LDR;
    end else begin
      last_gnt_q <= last_gnt_d;
    end
  end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module     : mem_port_arbiter                                    |
// | Description: Shares one single-port memory between the core and  |
// |              the loader; one access in flight, fixed latency.    |
// | Revision   : 1.0 - initial release                               |
// +------------------------------------------------------------------+
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned MEM_LAT = 1,
  parameter bit          RR      = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned     CW       = cnt_width(MEM_LAT);
  localparam logic [CW-1:0]   CNT_LOAD = CW'(MEM_LAT - 1);

  generate
    if (MEM_LAT < 1) begin : g_bad_lat
      $error("mem_port_arbiter: MEM_LAT must be at least 1");
    end
  endgenerate

  arb_state_e    state_q,     state_d;
  logic [CW-1:0] cnt_q,       cnt_d;
  logic          gnt_id_q,    gnt_id_d;
  logic          mem_we_q,    mem_we_d;
  logic [AW-1:0] mem_addr_q,  mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] rdata_q,     rdata_d;

  logic          arb_update;
  logic          arb_winner;
  logic          mem_en;
  logic          busy;
  logic          c_ack;
  logic          l_ack;

  rr_arb2 #(
    .RR (RR)
  ) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    ({bus.l_req, bus.c_req}),
    .update (arb_update),
    .winner (arb_winner)
  );

  // All state; async reset aborts any access and discards pending read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      gnt_id_q    <= PORT_CORE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gnt_id_q    <= gnt_id_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  // Sequencer: grant and latch in IDLE, strobe in ACCESS, count latency in WAIT
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gnt_id_d    = gnt_id_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    arb_update  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.c_req || bus.l_req) begin
          arb_update  = 1'b1;
          gnt_id_d    = arb_winner;
          mem_we_d    = (arb_winner == PORT_LDR) ? bus.l_we    : bus.c_we;
          mem_addr_d  = (arb_winner == PORT_LDR) ? bus.l_addr  : bus.c_addr;
          mem_wdata_d = (arb_winner == PORT_LDR) ? bus.l_wdata : bus.c_wdata;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        cnt_d   = CNT_LOAD;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rdata_d = bus.mem_rdata;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Strobes and status decoded from the registered state
  always_comb begin
    mem_en = (state_q == ACCESS);
    busy   = (state_q != IDLE);
    c_ack  = (state_q == RESP) && (gnt_id_q == PORT_CORE);
    l_ack  = (state_q == RESP) && (gnt_id_q == PORT_LDR);
  end

  assign bus.mem_en    = mem_en;
  assign bus.mem_we    = mem_we_q & mem_en;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rdata     = rdata_q;
  assign bus.c_ack     = c_ack;
  assign bus.l_ack     = l_ack;
  assign bus.busy      = busy;
  assign bus.gnt_id    = gnt_id_q;

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module     : tb_mem_port_arbiter                                 |
// | Description: Directed bench; instance A = MEM_LAT 1 round-robin, |
// |              instance B = MEM_LAT 3 fixed priority.              |
// | Revision   : 1.0 - initial release                               |
// +------------------------------------------------------------------+
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vecs = 0;
  int   errs = 0;
  int   mon_viol = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus_a ();
  mem_port_arbiter_if #(.AW(32), .DW(32)) bus_b ();

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .RR(1'b1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(3), .RR(1'b0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  // Memory models: read data appears exactly MEM_LAT cycles after mem_en, X otherwise
  logic [31:0] mem_a [256] = '{8'h10: 32'hDEADBEEF, 8'h11: 32'hCAFEF00D, default: 32'h0};
  logic [31:0] mem_b [256] = '{default: 32'h0};
  logic [31:0] pipe_a;
  logic [31:0] pipe_b [3];

  always @(posedge clk) begin
    if (bus_a.mem_en === 1'b1) begin
      if (bus_a.mem_we === 1'b1) mem_a[bus_a.mem_addr[7:0]] <= bus_a.mem_wdata;
      pipe_a <= (bus_a.mem_we === 1'b1) ? 32'hx : mem_a[bus_a.mem_addr[7:0]];
    end else begin
      pipe_a <= 32'hx;
    end
    if (bus_b.mem_en === 1'b1) begin
      if (bus_b.mem_we === 1'b1) mem_b[bus_b.mem_addr[7:0]] <= bus_b.mem_wdata;
      pipe_b[0] <= (bus_b.mem_we === 1'b1) ? 32'hx : mem_b[bus_b.mem_addr[7:0]];
    end else begin
      pipe_b[0] <= 32'hx;
    end
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end

  assign bus_a.mem_rdata = pipe_a;
  assign bus_b.mem_rdata = pipe_b[2];

  // Protocol monitor: no back-to-back mem_en, no double ack, no ack without a request
  logic prev_en_a = 1'b0, prev_en_b = 1'b0;
  logic pend_ca = 1'b0, pend_la = 1'b0, pend_cb = 1'b0, pend_lb = 1'b0;
  logic v_en, v_both, v_orphan;

  assign v_en     = (bus_a.mem_en & prev_en_a) | (bus_b.mem_en & prev_en_b);
  assign v_both   = (bus_a.c_ack & bus_a.l_ack) | (bus_b.c_ack & bus_b.l_ack);
  assign v_orphan = (bus_a.c_ack & ~pend_ca) | (bus_a.l_ack & ~pend_la) |
                    (bus_b.c_ack & ~pend_cb) | (bus_b.l_ack & ~pend_lb);

  always @(posedge clk) begin
    if (rst) begin
      prev_en_a <= 1'b0; prev_en_b <= 1'b0;
      pend_ca <= 1'b0; pend_la <= 1'b0; pend_cb <= 1'b0; pend_lb <= 1'b0;
    end else begin
      if (v_en || v_both || v_orphan) begin
        mon_viol <= mon_viol + 1;
        $display("FAIL monitor at %0t: en_twice=%b ack_both=%b ack_without_req=%b, required 0 0 0",
                 $time, v_en, v_both, v_orphan);
      end
      prev_en_a <= bus_a.mem_en;
      prev_en_b <= bus_b.mem_en;
      pend_ca <= bus_a.c_req ? 1'b1 : (bus_a.c_ack ? 1'b0 : pend_ca);
      pend_la <= bus_a.l_req ? 1'b1 : (bus_a.l_ack ? 1'b0 : pend_la);
      pend_cb <= bus_b.c_req ? 1'b1 : (bus_b.c_ack ? 1'b0 : pend_cb);
      pend_lb <= bus_b.l_req ? 1'b1 : (bus_b.l_ack ? 1'b0 : pend_lb);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vecs++; if ({bus_a.busy, bus_a.c_ack, bus_a.l_ack, bus_a.mem_en, bus_a.mem_we} !== 5'b0) begin
      errs++; $display("FAIL reset_ctrl_a: got %b required 00000",
                       {bus_a.busy, bus_a.c_ack, bus_a.l_ack, bus_a.mem_en, bus_a.mem_we}); end
    vecs++; if ({bus_b.busy, bus_b.c_ack, bus_b.l_ack, bus_b.mem_en, bus_b.mem_we} !== 5'b0) begin
      errs++; $display("FAIL reset_ctrl_b: got %b required 00000",
                       {bus_b.busy, bus_b.c_ack, bus_b.l_ack, bus_b.mem_en, bus_b.mem_we}); end
    vecs++; if ({bus_a.rdata, bus_a.mem_addr, bus_a.mem_wdata} !== 96'h0) begin
      errs++; $display("FAIL reset_data_a: got %h required 0", {bus_a.rdata, bus_a.mem_addr, bus_a.mem_wdata}); end
    vecs++; if ({bus_b.rdata, bus_b.mem_addr, bus_b.mem_wdata} !== 96'h0) begin
      errs++; $display("FAIL reset_data_b: got %h required 0", {bus_b.rdata, bus_b.mem_addr, bus_b.mem_wdata}); end
  endtask

  task automatic test_core_read();
    bus_a.c_req = 1'b1; bus_a.c_we = 1'b0; bus_a.c_addr = 32'h10; bus_a.c_wdata = 32'h0;
    @(negedge clk);
    vecs++; if ({bus_a.mem_en, bus_a.mem_we, bus_a.gnt_id, bus_a.busy} !== 4'b1001) begin
      errs++; $display("FAIL core_read_strobe: en/we/gnt/busy got %b required 1001",
                       {bus_a.mem_en, bus_a.mem_we, bus_a.gnt_id, bus_a.busy}); end
    vecs++; if (bus_a.mem_addr !== 32'h10) begin
      errs++; $display("FAIL core_read_addr: got %h required 00000010", bus_a.mem_addr); end
    @(negedge clk);
    vecs++; if ({bus_a.mem_en, bus_a.c_ack} !== 2'b00) begin
      errs++; $display("FAIL core_read_t2: en/ack got %b required 00", {bus_a.mem_en, bus_a.c_ack}); end
    @(negedge clk);
    vecs++; if ({bus_a.c_ack, bus_a.l_ack} !== 2'b10) begin
      errs++; $display("FAIL core_read_ack: c/l ack got %b required 10", {bus_a.c_ack, bus_a.l_ack}); end
    vecs++; if (bus_a.rdata !== 32'hDEADBEEF) begin
      errs++; $display("FAIL core_read_data: got %h required deadbeef", bus_a.rdata); end
    bus_a.c_req = 1'b0;
    @(negedge clk);
    vecs++; if ({bus_a.c_ack, bus_a.busy} !== 2'b00 || bus_a.rdata !== 32'hDEADBEEF) begin
      errs++; $display("FAIL core_read_after: ack/busy %b rdata %h required 00 deadbeef",
                       {bus_a.c_ack, bus_a.busy}, bus_a.rdata); end
  endtask

  task automatic test_loader_write();
    int pulses = 0, en_at = -1, acks = 0, ack_at = -1;
    logic we_seen = 1'b0;
    logic [31:0] addr_seen = 32'h0, wdata_seen = 32'h0, rd = 32'h0;
    bus_b.l_req = 1'b1; bus_b.l_we = 1'b1; bus_b.l_addr = 32'h40; bus_b.l_wdata = 32'h12345678;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (bus_b.mem_en === 1'b1) begin
        pulses++; en_at = k; we_seen = bus_b.mem_we;
        addr_seen = bus_b.mem_addr; wdata_seen = bus_b.mem_wdata;
      end
      if (bus_b.l_ack === 1'b1) begin acks++; ack_at = k; bus_b.l_req = 1'b0; end
    end
    bus_b.l_req = 1'b0; bus_b.l_we = 1'b0;
    vecs++; if (pulses !== 1 || en_at !== 1) begin
      errs++; $display("FAIL ldr_write_pulse: %0d pulses at %0d required 1 at 1", pulses, en_at); end
    vecs++; if (we_seen !== 1'b1 || addr_seen !== 32'h40 || wdata_seen !== 32'h12345678) begin
      errs++; $display("FAIL ldr_write_bus: we %b addr %h data %h required 1 00000040 12345678",
                       we_seen, addr_seen, wdata_seen); end
    vecs++; if (acks !== 1 || ack_at !== 5) begin
      errs++; $display("FAIL ldr_write_ack: %0d acks at %0d required 1 at 5", acks, ack_at); end
    acks = 0; ack_at = -1;
    bus_b.c_req = 1'b1; bus_b.c_we = 1'b0; bus_b.c_addr = 32'h40; bus_b.c_wdata = 32'h0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (bus_b.c_ack === 1'b1) begin acks++; ack_at = k; rd = bus_b.rdata; bus_b.c_req = 1'b0; end
    end
    bus_b.c_req = 1'b0;
    vecs++; if (acks !== 1 || ack_at !== 5 || rd !== 32'h12345678) begin
      errs++; $display("FAIL ldr_readback: %0d acks at %0d data %h required 1 at 5 12345678",
                       acks, ack_at, rd); end
  endtask

  task automatic test_round_robin();
    int ack_k[$];
    logic ack_p[$];
    logic [31:0] ack_d[$];
    logic exp_p;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    bus_a.c_req = 1'b1; bus_a.c_we = 1'b0; bus_a.c_addr = 32'h10;
    bus_a.l_req = 1'b1; bus_a.l_we = 1'b0; bus_a.l_addr = 32'h11; bus_a.l_wdata = 32'h0;
    for (int k = 1; k <= 23; k++) begin
      @(negedge clk);
      if (bus_a.c_ack === 1'b1) begin ack_k.push_back(k); ack_p.push_back(1'b0); ack_d.push_back(bus_a.rdata); end
      if (bus_a.l_ack === 1'b1) begin ack_k.push_back(k); ack_p.push_back(1'b1); ack_d.push_back(bus_a.rdata); end
    end
    bus_a.c_req = 1'b0; bus_a.l_req = 1'b0;
    vecs++; if (ack_k.size() !== 6) begin
      errs++; $display("FAIL rr_ack_count: got %0d required 6", ack_k.size()); end
    for (int i = 0; i < ack_k.size() && i < 6; i++) begin
      exp_p = (i % 2 != 0);
      vecs++; if (ack_p[i] !== exp_p || ack_k[i] !== 3 + 4 * i) begin
        errs++; $display("FAIL rr_grant_%0d: port %b at %0d required port %b at %0d",
                         i, ack_p[i], ack_k[i], exp_p, 3 + 4 * i); end
      vecs++; if (ack_d[i] !== (exp_p ? 32'hCAFEF00D : 32'hDEADBEEF)) begin
        errs++; $display("FAIL rr_data_%0d: got %h required %h", i, ack_d[i],
                         exp_p ? 32'hCAFEF00D : 32'hDEADBEEF); end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_fixed_priority();
    int c_acks = 0, last_c = -1, l_acks = 0, l_at = -1;
    logic [31:0] l_data = 32'h0;
    bus_b.c_req = 1'b1; bus_b.c_we = 1'b0; bus_b.c_addr = 32'h40;
    bus_b.l_req = 1'b1; bus_b.l_we = 1'b0; bus_b.l_addr = 32'h40;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus_b.c_ack === 1'b1) begin
        c_acks++; last_c = k;
        if (c_acks == 5) bus_b.c_req = 1'b0;
      end
      if (bus_b.l_ack === 1'b1) begin l_acks++; l_at = k; l_data = bus_b.rdata; bus_b.l_req = 1'b0; end
    end
    bus_b.c_req = 1'b0; bus_b.l_req = 1'b0;
    vecs++; if (c_acks !== 5 || last_c !== 29) begin
      errs++; $display("FAIL fixed_core_acks: %0d acks last at %0d required 5 last at 29", c_acks, last_c); end
    vecs++; if (l_acks !== 1 || l_at !== 35) begin
      errs++; $display("FAIL fixed_ldr_ack: %0d acks at %0d required 1 at 35", l_acks, l_at); end
    vecs++; if (l_data !== 32'h12345678) begin
      errs++; $display("FAIL fixed_ldr_data: got %h required 12345678", l_data); end
  endtask

  task automatic test_back_to_back();
    int en_k[$];
    int busy_low = 0, last_low = -10, adj_low = 0;
    bus_a.c_req = 1'b1; bus_a.c_we = 1'b0; bus_a.c_addr = 32'h10;
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      if (bus_a.mem_en === 1'b1) en_k.push_back(k);
      if (bus_a.busy === 1'b0) begin
        busy_low++;
        if (last_low == k - 1) adj_low++;
        last_low = k;
      end
      if (bus_a.c_ack === 1'b1 && k >= 19) bus_a.c_req = 1'b0;
    end
    bus_a.c_req = 1'b0;
    vecs++; if (en_k.size() !== 5) begin
      errs++; $display("FAIL b2b_pulses: got %0d required 5", en_k.size()); end
    for (int i = 1; i < en_k.size(); i++) begin
      vecs++; if (en_k[i] - en_k[i-1] !== 4) begin
        errs++; $display("FAIL b2b_gap_%0d: got %0d required 4", i, en_k[i] - en_k[i-1]); end
    end
    vecs++; if (busy_low !== 4 || adj_low !== 0) begin
      errs++; $display("FAIL b2b_idle: %0d idle cycles %0d adjacent required 4 0", busy_low, adj_low); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_in_wait();
    int acks = 0, ack_at = -1;
    logic [31:0] rd = 32'h0;
    bus_b.c_req = 1'b1; bus_b.c_we = 1'b0; bus_b.c_addr = 32'h40;
    repeat (2) @(negedge clk);
    vecs++; if ({bus_b.busy, bus_b.mem_en, bus_b.c_ack} !== 3'b100) begin
      errs++; $display("FAIL rstwait_pre: busy/en/ack got %b required 100",
                       {bus_b.busy, bus_b.mem_en, bus_b.c_ack}); end
    rst = 1'b1; bus_b.c_req = 1'b0;
    @(negedge clk);
    vecs++; if ({bus_b.busy, bus_b.mem_en, bus_b.mem_we, bus_b.c_ack, bus_b.l_ack} !== 5'b0) begin
      errs++; $display("FAIL rstwait_ctrl: got %b required 00000",
                       {bus_b.busy, bus_b.mem_en, bus_b.mem_we, bus_b.c_ack, bus_b.l_ack}); end
    vecs++; if ({bus_b.rdata, bus_b.mem_addr, bus_b.mem_wdata} !== 96'h0) begin
      errs++; $display("FAIL rstwait_data: got %h required 0", {bus_b.rdata, bus_b.mem_addr, bus_b.mem_wdata}); end
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (bus_b.c_ack === 1'b1 || bus_b.l_ack === 1'b1) acks++;
    end
    vecs++; if (acks !== 0) begin
      errs++; $display("FAIL rstwait_noack: got %0d acks required 0", acks); end
    bus_b.c_req = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (bus_b.c_ack === 1'b1) begin acks++; ack_at = k; rd = bus_b.rdata; bus_b.c_req = 1'b0; end
    end
    bus_b.c_req = 1'b0;
    vecs++; if (acks !== 1 || ack_at !== 5 || rd !== 32'h12345678) begin
      errs++; $display("FAIL rstwait_retry: %0d acks at %0d data %h required 1 at 5 12345678",
                       acks, ack_at, rd); end
  endtask

  task automatic test_protocol();
    repeat (2) @(negedge clk);
    vecs++; if (mon_viol !== 0) begin
      errs++; $display("FAIL protocol_monitor: got %0d violations required 0", mon_viol); end
  endtask

  initial begin
    bus_a.c_req = 1'b0; bus_a.c_we = 1'b0; bus_a.c_addr = 32'h0; bus_a.c_wdata = 32'h0;
    bus_a.l_req = 1'b0; bus_a.l_we = 1'b0; bus_a.l_addr = 32'h0; bus_a.l_wdata = 32'h0;
    bus_b.c_req = 1'b0; bus_b.c_we = 1'b0; bus_b.c_addr = 32'h0; bus_b.c_wdata = 32'h0;
    bus_b.l_req = 1'b0; bus_b.l_we = 1'b0; bus_b.l_addr = 32'h0; bus_b.l_wdata = 32'h0;
    test_reset();
    test_core_read();
    test_loader_write();
    test_round_robin();
    test_fixed_priority();
    test_back_to_back();
    test_reset_in_wait();
    test_protocol();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule : tb_mem_port_arbiter
`default_nettype wire
